regfile_arbiter: RTL and testbench

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

---
 rtl/regfile_arbiter.sv | 153 +++++++++++++++
 tb/tb_regfile_arbiter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter giving three pipeline requesters exclusive access to a
// register file with a READ_LAT-cycle read port and a single-cycle write port.
module regfile_arbiter #(
  parameter int READ_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [2:0]  req_we,
  input  logic [11:0] req_reg,
  input  logic [95:0] req_wdata,
  input  logic [2:0]  req_spsr,
  output logic [2:0]  ack,
  output logic [31:0] rdata,
  output logic        reg_read_en,
  output logic [3:0]  reg_read_reg,
  input  logic [31:0] reg_read_value,
  output logic        reg_write_en,
  output logic [3:0]  reg_write_reg,
  output logic [31:0] reg_write_value,
  output logic        reg_write_restore_from_SPSR,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  last_q;
  logic [2:0]  mask_q;
  logic [2:0]  wait_cnt;
  logic [1:0]  cur_idx;
  logic        cur_we;

  logic [2:0]  eligible;
  logic        grant_valid;
  logic [1:0]  grant_idx;
  logic [3:0]  sel_reg;
  logic [31:0] sel_wdata;

  // Requester index visited k-th when the search starts after the last winner.
  function automatic logic [1:0] rr_idx(input logic [1:0] last, input int k);
    int c;
    c = (int'(last) + 1 + k) % 3;
    return 2'(c);
  endfunction

  // mask_q holds the previous cycle's ack, so it only bites in the IDLE cycle
  // right after DONE, hiding a requester whose req drop is still in flight.
  assign eligible = req & ~mask_q;

  // NOTE: every variable gets a default before any branch so the block stays
  // purely combinational; a missing default would infer a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 2'd0;
    // Scan farthest-first so the nearest eligible requester wins.
    for (int k = 2; k >= 0; k--) begin
      if (eligible[rr_idx(last_q, k)]) begin
        grant_valid = 1'b1;
        grant_idx   = rr_idx(last_q, k);
      end
    end
  end

  always_comb begin
    sel_reg   = req_reg[4*grant_idx +: 4];
    sel_wdata = req_wdata[32*grant_idx +: 32];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = ISSUE;
      ISSUE:   state_d = (!cur_we && READ_LAT > 1) ? WAIT : DONE;
      WAIT:    if (wait_cnt == 3'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q                     <= IDLE;
      last_q                      <= 2'd2;
      mask_q                      <= 3'b000;
      wait_cnt                    <= 3'd0;
      cur_idx                     <= 2'd0;
      cur_we                      <= 1'b0;
      ack                         <= 3'b000;
      rdata                       <= 32'd0;
      reg_read_en                 <= 1'b0;
      reg_read_reg                <= 4'd0;
      reg_write_en                <= 1'b0;
      reg_write_reg               <= 4'd0;
      reg_write_value             <= 32'd0;
      reg_write_restore_from_SPSR <= 1'b0;
    end else begin
      state_q                     <= state_d;
      mask_q                      <= ack;
      ack                         <= 3'b000;
      reg_read_en                 <= 1'b0;
      reg_read_reg                <= 4'd0;
      reg_write_en                <= 1'b0;
      reg_write_reg               <= 4'd0;
      reg_write_value             <= 32'd0;
      reg_write_restore_from_SPSR <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            // The port registers double as the operand latch: they are loaded
            // once at grant and never look at req_* again.
            cur_idx <= grant_idx;
            cur_we  <= req_we[grant_idx];
            last_q  <= grant_idx;
            if (req_we[grant_idx]) begin
              reg_write_en                <= 1'b1;
              reg_write_reg               <= sel_reg;
              reg_write_value             <= sel_wdata;
              reg_write_restore_from_SPSR <= req_spsr[grant_idx];
            end else begin
              reg_read_en  <= 1'b1;
              reg_read_reg <= sel_reg;
            end
          end
        end
        ISSUE: begin
          if (!cur_we && READ_LAT > 1) begin
            wait_cnt <= 3'(READ_LAT - 2);
          end else begin
            if (!cur_we) rdata <= reg_read_value;
            ack <= 3'(1) << cur_idx;
          end
        end
        WAIT: begin
          if (wait_cnt == 3'd0) begin
            rdata <= reg_read_value;
            ack   <= 3'(1) << cur_idx;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy = rst ? (|req) : ((state_q != IDLE) || (|req));
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level round-robin model and a shadow register file.
module tb_regfile_arbiter;
  localparam int READ_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0;
  logic [2:0]  req_we = '0;
  logic [11:0] req_reg = '0;
  logic [95:0] req_wdata = '0;
  logic [2:0]  req_spsr = '0;
  logic [2:0]  ack;
  logic [31:0] rdata;
  logic        reg_read_en;
  logic [3:0]  reg_read_reg;
  logic [31:0] reg_read_value;
  logic        reg_write_en;
  logic [3:0]  reg_write_reg;
  logic [31:0] reg_write_value;
  logic        reg_write_restore_from_SPSR;
  logic        busy;

  int checks = 0;
  int errors = 0;

  regfile_arbiter #(.READ_LAT(READ_LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_reg(req_reg),
    .req_wdata(req_wdata), .req_spsr(req_spsr), .ack(ack), .rdata(rdata),
    .reg_read_en(reg_read_en), .reg_read_reg(reg_read_reg),
    .reg_read_value(reg_read_value), .reg_write_en(reg_write_en),
    .reg_write_reg(reg_write_reg), .reg_write_value(reg_write_value),
    .reg_write_restore_from_SPSR(reg_write_restore_from_SPSR), .busy(busy)
  );

  always #5 clk = ~clk;

  // Register file model: data is only valid in the cycle the arbiter samples it.
  logic [31:0] mem [16];
  logic        tb_wr_en = 1'b0;
  logic [3:0]  tb_wr_idx = '0;
  logic [31:0] tb_wr_val = '0;
  logic [2:0]  rd_age = '0;
  logic [3:0]  rd_reg_q = '0;
  int          cyc = 0;
  logic        read_ok;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tb_wr_en) mem[tb_wr_idx] <= tb_wr_val;
    else if (reg_write_en) mem[reg_write_reg] <= reg_write_value;
    if (reg_read_en) begin
      rd_age   <= 3'd1;
      rd_reg_q <= reg_read_reg;
    end else if (rd_age != 3'd0 && rd_age != 3'd7) begin
      rd_age <= rd_age + 3'd1;
    end
  end

  assign read_ok = (READ_LAT == 1) ? reg_read_en : (rd_age == 3'(READ_LAT - 1));
  assign reg_read_value = read_ok ? mem[(READ_LAT == 1) ? reg_read_reg : rd_reg_q]
                                  : (32'hBAD0_0000 ^ 32'(cyc));

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic preload(input logic [3:0] i, input logic [31:0] v);
    tb_wr_en = 1'b1; tb_wr_idx = i; tb_wr_val = v;
    @(negedge clk);
    tb_wr_en = 1'b0;
  endtask

  task automatic set_op(input int i, input logic we, input logic [3:0] r,
                        input logic [31:0] wd, input logic sp);
    req_we[i] = we;
    req_reg[4*i +: 4] = r;
    req_wdata[32*i +: 32] = wd;
    req_spsr[i] = sp;
  endtask

  function automatic int onehot_idx(input logic [2:0] a);
    case (a)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 3;
    endcase
  endfunction

  // Round-robin rule: first requesting index after the last winner, modulo 3.
  function automatic int rr_pick(input int last, input logic [2:0] r);
    for (int k = 1; k <= 3; k++) begin
      if (r[(last + k) % 3]) return (last + k) % 3;
    end
    return -1;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req = 3'b101;
    repeat (2) @(negedge clk);
    checks++;
    if ({ack, rdata, reg_read_en, reg_read_reg, reg_write_en, reg_write_reg,
         reg_write_value, reg_write_restore_from_SPSR} !== '0)
      begin errors++; $display("FAIL reset_outputs: outputs not all zero during reset"); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy_req: busy=%b want 1", busy); end
    req = 3'b000;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy_idle: busy=%b want 0", busy); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ack, reg_read_en, reg_write_en, busy} !== '0)
      begin errors++; $display("FAIL post_reset_idle: ack=%b ren=%b wen=%b busy=%b want 0",
                               ack, reg_read_en, reg_write_en, busy); end
  endtask

  task automatic test_single_read();
    int en_cnt = 0, en_at = -1, ack_at = -1, ack_cnt = 0;
    logic [3:0] seen_reg = '0;
    logic [2:0] ack_val = '0;
    logic [31:0] rd_val = '0;
    preload(4'd15, 32'h0000_0100);
    repeat (2) @(negedge clk);
    set_op(0, 1'b0, 4'd15, 32'h0, 1'b0);
    req = 3'b001;
    for (int t = 1; t <= 8; t++) begin
      @(negedge clk);
      if (reg_read_en) begin en_cnt++; en_at = t; seen_reg = reg_read_reg; end
      if (ack != 3'b000) begin
        ack_cnt++;
        if (ack_at < 0) begin ack_at = t; ack_val = ack; rd_val = rdata; end
        req = 3'b000;
      end
    end
    checks++;
    if (en_cnt != 1 || en_at != 1)
      begin errors++; $display("FAIL read_en_pulse: count=%0d at=%0d want 1 at 1", en_cnt, en_at); end
    checks++;
    if (seen_reg !== 4'd15) begin errors++; $display("FAIL read_reg: got %0d want 15", seen_reg); end
    checks++;
    if (ack_at != 1 + READ_LAT || ack_cnt != 1 || ack_val !== 3'b001)
      begin errors++; $display("FAIL read_ack: at=%0d cnt=%0d val=%b want at %0d cnt 1 val 001",
                               ack_at, ack_cnt, ack_val, 1 + READ_LAT); end
    checks++;
    if (rd_val !== 32'h0000_0100) begin errors++; $display("FAIL read_rdata: got %h want 00000100", rd_val); end
    checks++;
    if (rdata !== 32'h0000_0100) begin errors++; $display("FAIL rdata_hold: got %h want 00000100", rdata); end
  endtask

  task automatic test_single_write();
    int en_cnt = 0, en_at = -1, ack_at = -1, ren_cnt = 0;
    logic [2:0] ack_val = '0;
    logic [37:0] port = '0;
    repeat (3) @(negedge clk);
    set_op(1, 1'b1, 4'd3, 32'hDEAD_BEEF, 1'b1);
    req = 3'b010;
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      if (reg_read_en) ren_cnt++;
      if (reg_write_en) begin
        en_cnt++; en_at = t;
        port = {reg_write_restore_from_SPSR, reg_write_reg, reg_write_value, reg_write_en};
      end
      if (ack != 3'b000 && ack_at < 0) begin ack_at = t; ack_val = ack; req = 3'b000; end
    end
    checks++;
    if (en_cnt != 1 || en_at != 1 || ren_cnt != 0)
      begin errors++; $display("FAIL write_en_pulse: count=%0d at=%0d reads=%0d want 1 at 1, 0 reads",
                               en_cnt, en_at, ren_cnt); end
    checks++;
    if (port !== {1'b1, 4'd3, 32'hDEAD_BEEF, 1'b1})
      begin errors++; $display("FAIL write_port: got %h want %h", port, {1'b1, 4'd3, 32'hDEAD_BEEF, 1'b1}); end
    checks++;
    if (ack_at != 2 || ack_val !== 3'b010)
      begin errors++; $display("FAIL write_ack: at=%0d val=%b want at 2 val 010", ack_at, ack_val); end
  endtask

  task automatic test_contention();
    int order[6];
    int n = 0, busy_bad = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) set_op(i, 1'b1, 4'(8 + i), 32'(i), 1'b0);
    req = 3'b111;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 40 && n < 6; t++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_bad++;
      if (ack != 3'b000) begin order[n] = onehot_idx(ack); n++; end
    end
    req = 3'b000;
    checks++;
    if (n != 6) begin errors++; $display("FAIL contention_timeout: got %0d acks want 6", n); end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (order[k] != k % 3)
        begin errors++; $display("FAIL contention_order[%0d]: got %0d want %0d", k, order[k], k % 3); end
    end
    checks++;
    if (busy_bad != 0) begin errors++; $display("FAIL contention_busy: %0d low cycles want 0", busy_bad); end
  endtask

  task automatic test_stale();
    int got = 0, extra = 0, busy_hi = 0;
    repeat (3) @(negedge clk);
    set_op(0, 1'b1, 4'd4, 32'h0BAD_F00D, 1'b0);
    req = 3'b001;
    for (int t = 0; t < 10 && got == 0; t++) begin
      @(negedge clk);
      if (ack == 3'b001) got = 1;
    end
    checks++;
    if (got == 0) begin errors++; $display("FAIL stale_first_ack: no ack within 10 cycles want 1"); end
    @(negedge clk);
    req = 3'b000;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (reg_read_en || reg_write_en || ack != 3'b000) extra++;
      if (busy) busy_hi++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL stale_regrant: %0d active cycles want 0", extra); end
    checks++;
    if (busy_hi != 0) begin errors++; $display("FAIL stale_idle: busy high %0d cycles want 0", busy_hi); end
  endtask

  task automatic test_reset_mid_read();
    int got = 0, bad_ack = 0, wen_at = -1, ack_at = -1;
    logic [3:0] wreg = '0;
    repeat (3) @(negedge clk);
    set_op(1, 1'b0, 4'd7, 32'h0, 1'b0);
    req = 3'b010;
    for (int t = 0; t < 10 && got == 0; t++) begin
      @(negedge clk);
      if (reg_read_en) got = 1;
    end
    checks++;
    if (got == 0) begin errors++; $display("FAIL midread_issue: no read strobe within 10 cycles"); end
    @(negedge clk);
    rst = 1'b1;
    req = 3'b000;
    set_op(2, 1'b1, 4'd9, 32'h5555_AAAA, 1'b0);
    req = 3'b100;
    @(negedge clk);
    checks++;
    if ({ack, rdata, reg_read_en, reg_read_reg, reg_write_en, reg_write_reg,
         reg_write_value, reg_write_restore_from_SPSR} !== '0)
      begin errors++; $display("FAIL midread_reset_outputs: ack=%b rdata=%h not all zero", ack, rdata); end
    rst = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      @(negedge clk);
      if (ack == 3'b010) bad_ack++;
      if (reg_write_en && wen_at < 0) begin wen_at = t; wreg = reg_write_reg; end
      if (ack == 3'b100 && ack_at < 0) begin ack_at = t; req = 3'b000; end
    end
    checks++;
    if (bad_ack != 0) begin errors++; $display("FAIL midread_aborted_ack: %0d acks to requester 1 want 0", bad_ack); end
    checks++;
    if (wen_at != 1 || wreg !== 4'd9)
      begin errors++; $display("FAIL midread_regrant: strobe at %0d reg %0d want at 1 reg 9", wen_at, wreg); end
    checks++;
    if (ack_at != 2) begin errors++; $display("FAIL midread_ack: at %0d want 2", ack_at); end
  endtask

  task automatic test_operand_isolation();
    int ack_at = -1, both = 0;
    logic [3:0] rreg = '0;
    logic [31:0] rd_val = '0;
    logic [37:0] port = '0;
    preload(4'd6, 32'h1234_5678);
    preload(4'd2, 32'h8765_4321);
    repeat (2) @(negedge clk);
    set_op(2, 1'b0, 4'd6, 32'h0, 1'b0);
    req = 3'b100;
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      if (reg_read_en && reg_write_en) both++;
      if (reg_read_en) rreg = reg_read_reg;
      if (t == 1) set_op(2, 1'b1, 4'd2, 32'hFFFF_FFFF, 1'b1);
      if (ack == 3'b100 && ack_at < 0) begin ack_at = t; rd_val = rdata; req = 3'b000; end
    end
    checks++;
    if (rreg !== 4'd6 || rd_val !== 32'h1234_5678 || ack_at != 1 + READ_LAT)
      begin errors++; $display("FAIL isolation_read: reg=%0d rdata=%h at=%0d want 6 12345678 at %0d",
                               rreg, rd_val, ack_at, 1 + READ_LAT); end
    repeat (2) @(negedge clk);
    set_op(0, 1'b1, 4'd11, 32'hCAFE_F00D, 1'b0);
    req = 3'b001;
    ack_at = -1;
    for (int t = 1; t <= 5; t++) begin
      @(negedge clk);
      if (reg_read_en && reg_write_en) both++;
      if (reg_write_en) port = {reg_write_restore_from_SPSR, reg_write_reg, reg_write_value, reg_write_en};
      set_op(0, 1'b0, 4'd1, 32'h0000_0000, 1'b1);
      if (ack == 3'b001 && ack_at < 0) begin ack_at = t; req = 3'b000; end
    end
    checks++;
    if (port !== {1'b0, 4'd11, 32'hCAFE_F00D, 1'b1} || ack_at != 2)
      begin errors++; $display("FAIL isolation_write: port=%h at=%0d want %h at 2",
                               port, ack_at, {1'b0, 4'd11, 32'hCAFE_F00D, 1'b1}); end
    checks++;
    if (both != 0) begin errors++; $display("FAIL isolation_exclusive: %0d cycles with both enables want 0", both); end
  endtask

  task automatic test_random();
    logic [31:0] exp_mem [16];
    int cool[3] = '{0, 0, 0};
    bit in_flight = 0, acked, strobe, exp_strobe, wop = 0;
    int age = 0, due = 0, win = 0, gap = 0, last_m = 2, acks = 0, w;
    logic [31:0] exp_rd = '0, rdata_m = '0;
    logic [3:0] r;
    logic [31:0] wd;
    @(negedge clk);
    rst = 1'b1; req = 3'b000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_mem[i] = $urandom;
      preload(4'(i), exp_mem[i]);
    end
    for (int n = 0; n < 4000 && acks < 120; n++) begin
      @(negedge clk);
      acked = 0;
      strobe = reg_read_en | reg_write_en;
      checks++;
      if (reg_read_en && reg_write_en) begin errors++; $display("FAIL rand_exclusive: both enables high"); end
      if (!in_flight) begin
        exp_strobe = 0;
        if (gap > 0) gap--;
        else exp_strobe = |req;
        checks++;
        if (strobe !== exp_strobe || ack !== 3'b000)
          begin errors++; $display("FAIL rand_issue: strobe=%b ack=%b want strobe %b ack 000",
                                   strobe, ack, exp_strobe); end
        if (strobe && exp_strobe) begin
          w  = rr_pick(last_m, req);
          r  = req_reg[4*w +: 4];
          wd = req_wdata[32*w +: 32];
          wop = req_we[w];
          checks++;
          if (wop) begin
            if ({reg_write_en, reg_read_en, reg_write_reg, reg_write_value, reg_write_restore_from_SPSR}
                !== {1'b1, 1'b0, r, wd, req_spsr[w]})
              begin errors++; $display("FAIL rand_write_port: reg=%0d val=%h spsr=%b want reg %0d val %h spsr %b (req %0d)",
                                       reg_write_reg, reg_write_value, reg_write_restore_from_SPSR, r, wd, req_spsr[w], w); end
            exp_mem[r] = wd;
          end else begin
            if ({reg_read_en, reg_write_en, reg_read_reg} !== {1'b1, 1'b0, r})
              begin errors++; $display("FAIL rand_read_port: ren=%b reg=%0d want 1 reg %0d (req %0d)",
                                       reg_read_en, reg_read_reg, r, w); end
            exp_rd = exp_mem[r];
          end
          in_flight = 1; age = 0; due = wop ? 1 : READ_LAT; win = w; last_m = w;
        end
      end else begin
        age++;
        checks++;
        if (strobe) begin errors++; $display("FAIL rand_overlap: strobe while transaction in flight"); end
        checks++;
        if (age == due) begin
          if (ack !== 3'(1 << win))
            begin errors++; $display("FAIL rand_ack: got %b want %b", ack, 3'(1 << win)); end
          if (!wop) rdata_m = exp_rd;
          in_flight = 0; acked = 1; gap = 1; acks++;
        end else if (ack !== 3'b000) begin
          errors++; $display("FAIL rand_early_ack: got %b want 000", ack);
        end
      end
      checks++;
      if (rdata !== rdata_m) begin errors++; $display("FAIL rand_rdata: got %h want %h", rdata, rdata_m); end
      checks++;
      if (busy !== (in_flight || acked || (|req)))
        begin errors++; $display("FAIL rand_busy: got %b want %b", busy, in_flight || acked || (|req)); end
      if (acked) begin req[win] = 1'b0; cool[win] = 2 + int'($urandom_range(0, 2)); end
      for (int i = 0; i < 3; i++) begin
        if (!req[i]) begin
          if (cool[i] > 0) cool[i]--;
          else if ($urandom_range(0, 3) == 0) begin
            set_op(i, 1'($urandom), 4'($urandom), $urandom, 1'($urandom));
            req[i] = 1'b1;
          end
        end else if (in_flight && i == win) begin
          set_op(i, 1'($urandom), 4'($urandom), $urandom, 1'($urandom));
        end
      end
    end
    req = 3'b000;
    checks++;
    if (acks < 120) begin errors++; $display("FAIL rand_timeout: %0d acks want 120", acks); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_stale();
    test_reset_mid_read();
    test_operand_isolation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
